// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared definitions for the keyboard-to-cursor control slice.
//   * PS/2 set-2 scancode constants (prefixes and the keys acted upon)
//   * prefix-state type used by kbd_prefix_fsm
//   * default character-grid geometry (640x480 px in 8x8 px cells)
package kbd_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended (E0-prefixed) make codes: arrow keys
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Normal make codes
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

    localparam int GRID_W_DEF = 80;
    localparam int GRID_H_DEF = 60;
    localparam int X_W_DEF    = 7;
    localparam int Y_W_DEF    = 6;

endpackage

// File: rtl/kbd_prefix_fsm.sv
// kbd_prefix_fsm -- strips set-2 E0/F0 prefixes from the scancode stream.
//
// Ports:
//   clk       in   pixel-domain clock
//   reset     in   synchronous, active-low reset
//   scancode  in   byte from the keyboard protocol block
//   enable    in   one-cycle strobe, scancode holds a new byte
//   code_vld  out  a make code completes on this cycle (combinational)
//   code      out  the make code itself (valid with code_vld)
//   is_ext    out  the make code was E0-prefixed (valid with code_vld)
//
// code_vld is decoded combinationally from the current prefix state and the
// incoming byte, so the downstream registers apply the action on the same
// edge that samples the final byte. Break sequences never raise code_vld.
module kbd_prefix_fsm
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       enable,
    output logic       code_vld,
    output logic [7:0] code,
    output logic       is_ext
);

    prefix_state_t state, state_nxt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        code_vld  = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (scancode == SC_EXT)      state_nxt = EXT;
                    else if (scancode == SC_BRK) state_nxt = BRK;
                    else                         code_vld  = 1'b1;
                end
                EXT: begin
                    // A repeated E0 keeps the extended context alive.
                    if (scancode == SC_BRK)      state_nxt = EXT_BRK;
                    else if (scancode != SC_EXT) begin
                        code_vld  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                // Releases are swallowed: the byte after F0 is dropped.
                BRK, EXT_BRK: state_nxt = IDLE;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    assign code   = scancode;
    assign is_ext = (state == EXT);

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// kbd_cursor_ctrl -- turns keyboard make codes into cursor position, colour
// selection and pen state for the VGA pixel stage.
//
// Ports:
//   clk        in   pixel-domain clock (25 MHz)
//   reset      in   synchronous, active-low reset
//   scancode   in   byte from the keyboard protocol block
//   enable     in   one-cycle strobe, scancode holds a new byte
//   cur_x      out  cursor column, 0..GRID_W-1
//   cur_y      out  cursor row, 0..GRID_H-1
//   red_sel    out  selected red level
//   green_sel  out  selected green level
//   blue_sel   out  selected blue level
//   pen_down   out  1 = paint the cursor cell with the selected colour
//   key_evt    out  one-cycle pulse, a recognised action was applied
//
// Build option: define KBD_CURSOR_WRAP_EN to make cursor moves wrap around
// the grid edges; by default they saturate at the edges.
module kbd_cursor_ctrl
    import kbd_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     scancode,
    input  logic           enable,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic [2:0]     red_sel,
    output logic [2:0]     green_sel,
    output logic [2:0]     blue_sel,
    output logic           pen_down,
    output logic           key_evt
);

    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

    // Position taken by a move that would step off the grid.
`ifdef KBD_CURSOR_WRAP_EN
    localparam logic [X_W-1:0] X_PAST_LEFT  = X_MAX;
    localparam logic [X_W-1:0] X_PAST_RIGHT = '0;
    localparam logic [Y_W-1:0] Y_PAST_UP    = Y_MAX;
    localparam logic [Y_W-1:0] Y_PAST_DOWN  = '0;
`else
    localparam logic [X_W-1:0] X_PAST_LEFT  = '0;
    localparam logic [X_W-1:0] X_PAST_RIGHT = X_MAX;
    localparam logic [Y_W-1:0] Y_PAST_UP    = '0;
    localparam logic [Y_W-1:0] Y_PAST_DOWN  = Y_MAX;
`endif

    logic       code_vld;
    logic [7:0] code;
    logic       is_ext;

    kbd_prefix_fsm u_prefix (
        .clk      (clk),
        .reset    (reset),
        .scancode (scancode),
        .enable   (enable),
        .code_vld (code_vld),
        .code     (code),
        .is_ext   (is_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_x     <= '0;
            cur_y     <= '0;
            red_sel   <= 3'd7;
            green_sel <= 3'd7;
            blue_sel  <= 3'd7;
            pen_down  <= 1'b0;
            key_evt   <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            if (code_vld) begin
                if (is_ext) begin
                    case (code)
                        SC_UP: begin
                            key_evt <= 1'b1;
                            cur_y   <= (cur_y == '0) ? Y_PAST_UP : cur_y - 1'b1;
                        end
                        SC_DOWN: begin
                            key_evt <= 1'b1;
                            cur_y   <= (cur_y == Y_MAX) ? Y_PAST_DOWN : cur_y + 1'b1;
                        end
                        SC_LEFT: begin
                            key_evt <= 1'b1;
                            cur_x   <= (cur_x == '0) ? X_PAST_LEFT : cur_x - 1'b1;
                        end
                        SC_RIGHT: begin
                            key_evt <= 1'b1;
                            cur_x   <= (cur_x == X_MAX) ? X_PAST_RIGHT : cur_x + 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    // Colour levels roll over modulo 8 by natural overflow.
                    case (code)
                        SC_R: begin
                            key_evt <= 1'b1;
                            red_sel <= red_sel + 3'd1;
                        end
                        SC_G: begin
                            key_evt   <= 1'b1;
                            green_sel <= green_sel + 3'd1;
                        end
                        SC_B: begin
                            key_evt  <= 1'b1;
                            blue_sel <= blue_sel + 3'd1;
                        end
                        SC_SPACE: begin
                            key_evt  <= 1'b1;
                            pen_down <= ~pen_down;
                        end
                        SC_ESC: begin
                            key_evt  <= 1'b1;
                            cur_x    <= '0;
                            cur_y    <= '0;
                            pen_down <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_kbd_cursor_ctrl.sv
// tb_kbd_cursor_ctrl -- directed self-checking bench for kbd_cursor_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed the byte. Expected values are written
// out by hand, with the edge outcomes selected by KBD_CURSOR_WRAP_EN.
module tb_kbd_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scancode;
    logic       enable;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic [2:0] red_sel, green_sel, blue_sel;
    logic       pen_down, key_evt;

    int errors = 0;
    int checks = 0;

`ifdef KBD_CURSOR_WRAP_EN
    localparam int EXP_UP_EDGE    = 59;
    localparam int EXP_LEFT_EDGE  = 79;
    localparam int EXP_RIGHT_EDGE = 0;
    localparam int EXP_DOWN_65    = 5;
`else
    localparam int EXP_UP_EDGE    = 0;
    localparam int EXP_LEFT_EDGE  = 0;
    localparam int EXP_RIGHT_EDGE = 79;
    localparam int EXP_DOWN_65    = 59;
`endif

    kbd_cursor_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .scancode  (scancode),
        .enable    (enable),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .red_sel   (red_sel),
        .green_sel (green_sel),
        .blue_sel  (blue_sel),
        .pen_down  (pen_down),
        .key_evt   (key_evt)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y, input int r,
                             input int g, input int b, input int pen, input int evt);
        check({tag, ".cur_x"},     32'(cur_x),     x);
        check({tag, ".cur_y"},     32'(cur_y),     y);
        check({tag, ".red_sel"},   32'(red_sel),   r);
        check({tag, ".green_sel"}, 32'(green_sel), g);
        check({tag, ".blue_sel"},  32'(blue_sel),  b);
        check({tag, ".pen_down"},  32'(pen_down),  pen);
        check({tag, ".key_evt"},   32'(key_evt),   evt);
    endtask

    // Presents one byte for one cycle; returns on the next falling edge,
    // where that byte's effect is visible. Consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        scancode = b;
        enable   = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        scancode = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_all("reset", 0, 0, 7, 7, 7, 0, 0);

        // 1: E0,74 -> right one column
        send(8'hE0);
        check("t1_prefix_evt", 32'(key_evt), 0);
        send(8'h74);
        check_all("t1_right", 1, 0, 7, 7, 7, 0, 1);
        @(negedge clk);
        check("t1_evt_one_cycle", 32'(key_evt), 0);

        // 2: moves off the top-left corner
        send(8'h76);
        check_all("t2_esc", 0, 0, 7, 7, 7, 0, 1);
        send(8'hE0); send(8'h75);
        check_all("t2_up_edge", 0, EXP_UP_EDGE, 7, 7, 7, 0, 1);
        send(8'hE0); send(8'h6B);
        check_all("t2_left_edge", EXP_LEFT_EDGE, EXP_UP_EDGE, 7, 7, 7, 0, 1);
        send(8'h76);
        check_all("t2_esc2", 0, 0, 7, 7, 7, 0, 1);

        // 3: red make then release; extended release ignored
        send(8'h2D);
        check_all("t3_red", 0, 0, 0, 7, 7, 0, 1);
        send(8'hF0);
        check("t3_brk_evt", 32'(key_evt), 0);
        send(8'h2D);
        check_all("t3_red_release", 0, 0, 0, 7, 7, 0, 0);
        send(8'hE0);
        check("t3_e0_evt", 32'(key_evt), 0);
        send(8'hF0);
        check("t3_e0f0_evt", 32'(key_evt), 0);
        send(8'h74);
        check_all("t3_ext_release", 0, 0, 0, 7, 7, 0, 0);
        send(8'h32);
        check_all("t3_blue", 0, 0, 0, 7, 0, 0, 1);

        // 4: repeated E0, moves, pen, green, Esc
        send(8'hE0); send(8'hE0);
        check("t4_e0e0_evt", 32'(key_evt), 0);
        send(8'h74);
        check_all("t4_e0e0_right", 1, 0, 0, 7, 0, 0, 1);
        send(8'hE0); send(8'h74);
        send(8'hE0); send(8'h72);
        check_all("t4_moved", 2, 1, 0, 7, 0, 0, 1);
        send(8'h29);
        check_all("t4_pen", 2, 1, 0, 7, 0, 1, 1);
        send(8'h34);
        check("t4_green0", 32'(green_sel), 0);
        send(8'h34);
        check("t4_green1", 32'(green_sel), 1);
        send(8'h34);
        check("t4_green2", 32'(green_sel), 2);
        send(8'h76);
        check_all("t4_esc", 0, 0, 0, 2, 0, 0, 1);

        // Right edge: 79 moves reach the last column, one more hits the edge
        for (int i = 0; i < 79; i++) begin
            send(8'hE0); send(8'h74);
        end
        check("t_right_last_col", 32'(cur_x), 79);
        send(8'hE0); send(8'h74);
        check_all("t_right_edge", EXP_RIGHT_EDGE, 0, 0, 2, 0, 0, 1);
        send(8'h76);

        // 6: 65 typematic down moves from row 0
        for (int i = 0; i < 65; i++) begin
            send(8'hE0); send(8'h72);
        end
        check_all("t6_down65", 0, EXP_DOWN_65, 0, 2, 0, 0, 1);

        // 5: reset after E0 discards the prefix
        send(8'hE0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all("t5_reset", 0, 0, 7, 7, 7, 0, 0);
        send(8'h74);
        check_all("t5_no_move", 0, 0, 7, 7, 7, 0, 0);
        send(8'h1C);
        check_all("t5_unknown", 0, 0, 7, 7, 7, 0, 0);
        send(8'h2D);
        check_all("t5_idle_decode", 0, 0, 0, 7, 7, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
